configurable_seq_multiplier: RTL and testbench
==============================================

# configurable_seq_multiplier

Parametrised sequential multiplier: the successor to the single-mode shift-add multiplier. It adds a per-operation signed/unsigned mode, a configurable number of multiplier bits retired per clock, and a synchronous reset. It has a busy/ready handshake so a controller or bench can issue back-to-back products. It sits wherever a multi-cycle WIDTH×WIDTH product is cheaper than a full combinational array.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 2.
- BITS_PER_CYCLE, 1, multiplier bits consumed per iteration; must divide WIDTH (legal for WIDTH=8: 1, 2, 4, 8).
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- ina  input  WIDTH  multiplicand; sampled only on the accepting edge.
- inb  input  WIDTH  multiplier; sampled only on the accepting edge.
- is_signed  input  1  1 = both operands two's complement; 0 = both unsigned; sampled on the accepting edge.
- start  input  1  request a new product; level-sampled.
- out  output  2*WIDTH  result of the most recent completed operation.
- ready  output  1  high while out holds a valid completed result and the block is idle.
- busy  output  1  high while an operation is in flight.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1; N = WIDTH/BITS_PER_CYCLE iterations.
  - FIX: busy=1; one cycle.
- Accept rule: start=1 at a rising edge while busy=0 → latch ina, inb, is_signed; clear accumulator and iteration counter; go to RUN; ready←0.
- start while busy=1 is ignored; no queueing and no effect on the current operation.
- Signed mode:
  - Latch the absolute values of both operands as WIDTH-bit unsigned magnitudes; |−2^(WIDTH−1)| = 2^(WIDTH−1) is representable.
  - Latch neg = sign(ina) XOR sign(inb).
  - In unsigned mode, neg = 0 and operands are used as-is.
- RUN iteration:
  - acc += mcand × (low BITS_PER_CYCLE bits of mplier) << (k × BITS_PER_CYCLE), for k = 0…N−1.
  - Equivalent: a right-shifting product register. Implementation choice, bit-exact result required.
  - The accumulator is 2*WIDTH bits and never overflows.
- FIX: out ← neg ? (−acc mod 2^(2W)) : acc; then go to IDLE with ready←1, busy←0.
- out changes only in FIX and on reset. During RUN, out keeps the previous result (ready=0 flags it stale).
- Operand value never shortens latency. Zero operands take the full N+1 cycles.
- Signed results are exact two's complement in 2*WIDTH bits; the worst case (−2^(W−1))² = 2^(2W−2) fits.

## Timing
- Reset: out=0, ready=0, busy=0, state IDLE; the counter and accumulator are cleared. Reset has priority over start on the same edge.
- Accepting edge E0 → busy=1, ready=0 visible after E0.
- Edges E1…EN perform the iterations.
- Edge EN+1 (FIX) writes out; busy=0, ready=1 are visible after EN+1. Latency: N+1 cycles from the accepting edge to ready.
- Back-to-back: start may be held high continuously. It is accepted on the first edge after busy falls, so the throughput is one product per N+2 cycles.
- Reset mid-operation:
  - Abort immediately; out=0, ready=0, busy=0 after the reset edge.
  - The aborted result is never produced.
  - start is honoured again on the first edge with rst=0.
- ready stays high indefinitely in IDLE until the next accept. It falls together with busy rising on the accepting edge.
- After reset and before the first completed operation, ready=0 even though busy=0.

## Test plan
- Reset: assert rst for 2 cycles with start=1 → out=0x0000, ready=0, busy=0 throughout. The first accept occurs on the first edge with rst low.
- Unsigned, WIDTH=8, BITS_PER_CYCLE=1:
  - ina=255, inb=255, is_signed=0 → ready rises 9 cycles after the accepting edge; out=65025 (0xFE01).
  - ina=0, inb=200 → out=0, still 9 cycles.
- Signed, WIDTH=8:
  - ina=0x80, inb=0x80 → out=0x4000 (16384).
  - ina=0xFF, inb=0x7F → out=0xFF81 (−127).
  - Same bits with is_signed=0 → out=32385 (0x7E81).
- Busy protection: accept 12×11, then pulse start with ina=3, inb=3 during RUN → out=132, busy falls once, and no second operation starts.
- Reset mid-op:
  - Accept 200×200, assert rst at iteration 4 → out=0, ready=0 next cycle.
  - Then 7×6 → out=42 after the full latency.
- Radix: BITS_PER_CYCLE=4, random 1000 pairs in both modes against a reference model → exact match and 3-cycle latency every time. Hold start high continuously → a new accept every 4 cycles.

Source files
------------

// File: rtl/configurable_seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, signed or unsigned per operation, BITS_PER_CYCLE multiplier bits per clock.
// Latency WIDTH/BITS_PER_CYCLE+1 cycles from accept to ready; start is ignored while busy (no queueing).
module configurable_seq_multiplier #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     ina,
    input  logic [WIDTH-1:0]     inb,
    input  logic                 is_signed,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   out,
    output logic                 ready,
    output logic                 busy
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   out_q, out_d;
    logic            ready_q, ready_d;

    logic            last_iter;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]   pp;

    assign last_iter = (cnt_q == CW'(N - 1));

    // Signed operands become magnitudes; -2^(WIDTH-1) maps onto itself as an unsigned value.
    always_comb begin
        mag_a = (is_signed && ina[WIDTH-1]) ? -ina : ina;
        mag_b = (is_signed && inb[WIDTH-1]) ? -inb : inb;
        pp    = mcand_q * PW'(mplier_q[BITS_PER_CYCLE-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        ready_d  = ready_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = PW'(mag_a);
                    mplier_d = mag_b;
                    neg_d    = is_signed & (ina[WIDTH-1] ^ inb[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                end
            end
            S_RUN: begin
                // Multiplicand shifts up as the multiplier shifts down, so each digit lands at its weight.
                acc_d    = acc_q + pp;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + CW'(1);
            end
            S_FIX: begin
                out_d   = neg_q ? -acc_q : acc_q;
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ready_q  <= ready_d;
        end
    end

    assign out   = out_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_configurable_seq_multiplier.sv
// Directed and randomized checks of the sequential multiplier at radix 1 (dut0) and radix 4 (dut1).
module tb_configurable_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a0, b0, a1, b1;
    logic        s0, s1, st0, st1;
    logic [15:0] out0, out1;
    logic        rdy0, rdy1, busy0, busy1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    configurable_seq_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst(rst), .ina(a0), .inb(b0), .is_signed(s0), .start(st0),
        .out(out0), .ready(rdy0), .busy(busy0)
    );

    configurable_seq_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut1 (
        .clk(clk), .rst(rst), .ina(a1), .inb(b1), .is_signed(s1), .start(st1),
        .out(out1), .ready(rdy1), .busy(busy1)
    );

    function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepting edge on dut0 and checks the handshake right after it.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
        a0 = a; b0 = b; s0 = s; st0 = 1'b1;
        tick();
        st0 = 1'b0;
        chk({tag, "_busy_after_accept"}, 32'(busy0), 32'd1);
        chk({tag, "_ready_after_accept"}, 32'(rdy0), 32'd0);
    endtask

    task automatic wait_done(input int n0, input int exp_lat, input logic [15:0] exp_out, input string tag);
        int n;
        n = n0;
        do begin
            tick();
            n++;
        end while (!rdy0 && n < 40);
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_out"}, 32'(out0), 32'(exp_out));
        chk({tag, "_busy_done"}, 32'(busy0), 32'd0);
    endtask

    initial begin
        logic [15:0] prev;
        rst = 1'b1;
        a0 = '0; b0 = '0; s0 = 1'b0; st0 = 1'b1;
        a1 = '0; b1 = '0; s1 = 1'b0; st1 = 1'b1;

        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out", 32'(out0), 32'd0);
            chk("rst_ready", 32'(rdy0), 32'd0);
            chk("rst_busy", 32'(busy0), 32'd0);
            chk("rst_busy_r4", 32'(busy1), 32'd0);
            chk("rst_ready_r4", 32'(rdy1), 32'd0);
        end
        st1 = 1'b0;
        rst = 1'b0;

        // start is still high, so the first edge with rst low accepts
        start_op(8'd255, 8'd255, 1'b0, "u255x255");
        wait_done(0, 9, 16'hFE01, "u255x255");
        tick(); tick(); tick();
        chk("ready_holds", 32'(rdy0), 32'd1);
        chk("out_holds", 32'(out0), 32'hFE01);

        start_op(8'd0, 8'd200, 1'b0, "u0x200");
        chk("out_stale_during_run", 32'(out0), 32'hFE01);
        wait_done(0, 9, 16'h0000, "u0x200");

        start_op(8'h80, 8'h80, 1'b1, "s80x80");
        wait_done(0, 9, 16'h4000, "s80x80");
        start_op(8'hFF, 8'h7F, 1'b1, "sFFx7F");
        wait_done(0, 9, 16'hFF81, "sFFx7F");
        start_op(8'hFF, 8'h7F, 1'b0, "uFFx7F");
        wait_done(0, 9, 16'h7E81, "uFFx7F");

        // start pulse during RUN must not disturb or queue
        start_op(8'd12, 8'd11, 1'b0, "busyprot");
        tick(); tick();
        a0 = 8'd3; b0 = 8'd3; st0 = 1'b1;
        tick();
        st0 = 1'b0;
        wait_done(3, 9, 16'd132, "busyprot");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("busyprot_no_second_op", 32'(busy0), 32'd0);
        end
        chk("busyprot_out_kept", 32'(out0), 32'd132);

        start_op(8'd200, 8'd200, 1'b0, "abort");
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out", 32'(out0), 32'd0);
        chk("abort_ready", 32'(rdy0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        start_op(8'd7, 8'd6, 1'b0, "after_abort");
        wait_done(0, 9, 16'd42, "after_abort");

        // Radix 4: start held high, so each op is accept + 2 iterations + FIX, then the next accept.
        prev = out1;
        st1 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] exp;
            a1 = 8'($urandom);
            b1 = 8'($urandom);
            s1 = 1'($urandom_range(0, 1));
            exp = model_mul(a1, b1, s1);
            tick();
            chk("r4_busy_accept", 32'(busy1), 32'd1);
            a1 = 8'($urandom);
            b1 = 8'($urandom);
            tick();
            tick();
            chk("r4_busy_run", 32'(busy1), 32'd1);
            chk("r4_ready_run", 32'(rdy1), 32'd0);
            chk("r4_out_stale", 32'(out1), 32'(prev));
            tick();
            chk("r4_ready_done", 32'(rdy1), 32'd1);
            chk("r4_busy_done", 32'(busy1), 32'd0);
            chk("r4_product", 32'(out1), 32'(exp));
            prev = exp;
        end
        st1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
